// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and constants for the operand bypass network.
package cpu_types_pkg;

    localparam int CPU_DATA_W       = 32;
    localparam int CPU_REG_AW       = 5;
    localparam int BYPASS_DEPTH_MAX = 8;

    // In-flight write record at the default datapath widths.
    typedef struct packed {
        logic                  valid;
        logic [CPU_REG_AW-1:0] rd;
        logic [CPU_DATA_W-1:0] data;
        logic                  ready;
    } bypass_slot_t;

    // Width of a select that encodes "register file" plus one code per slot.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bypass_port_sel.sv
// Per-port operand select: youngest matching in-flight slot, else register file.
module bypass_port_sel #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = 2
) (
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [DEPTH-1:0][REG_AW-1:0] rd_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
    input  logic [DEPTH-1:0]             ready_i,
    input  logic [REG_AW-1:0]            rs_i,
    input  logic [DATA_W-1:0]            rf_data_i,
    output logic [DATA_W-1:0]            op_data_o,
    output logic [SEL_W-1:0]             fwd_sel_o,
    output logic                         stall_o
);

    // Scan oldest to youngest so the youngest match overrides; readiness comes
    // from the winner only, so an older ready copy never hides a pending load.
    always_comb begin
        op_data_o = rf_data_i;
        fwd_sel_o = '0;
        stall_o   = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_i[i] && (rd_i[i] == rs_i) && (rs_i != '0)) begin
                op_data_o = data_i[i];
                fwd_sel_o = SEL_W'(i + 1);
                stall_o   = !ready_i[i];
            end
        end
    end

endmodule

// File: rtl/operand_bypass_net.sv
// Operand forwarding network: in-flight write pipeline, late load fill and
// per-port youngest-producer lookup with load-use stall.
module operand_bypass_net
    import cpu_types_pkg::*;
#(
    parameter  int DATA_W     = CPU_DATA_W,
    parameter  int REG_AW     = CPU_REG_AW,
    parameter  int DEPTH      = 3,
    parameter  int NPORTS     = 2,
    parameter  int LOAD_STAGE = 1,
    localparam int SEL_W      = sel_width(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     advance,
    input  logic                     flush,
    input  logic                     new_wen,
    input  logic [REG_AW-1:0]        new_rd,
    input  logic [DATA_W-1:0]        new_data,
    input  logic                     new_ready,
    input  logic                     fill_en,
    input  logic [DATA_W-1:0]        fill_data,
    input  logic [NPORTS*REG_AW-1:0] rs,
    input  logic [NPORTS*DATA_W-1:0] rf_data,
    output logic [NPORTS*DATA_W-1:0] op_data,
    output logic [NPORTS*SEL_W-1:0]  fwd_sel,
    output logic                     stall
);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             ready_q, ready_d;
    logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic                         fill_hit;
    logic [NPORTS-1:0]            port_stall;

    assign fill_hit = fill_en && valid_q[LOAD_STAGE] && !ready_q[LOAD_STAGE];

    // Fill is applied before the shift so a same-cycle fill travels with its entry.
    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        rd_d    = rd_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (fill_hit) begin
                data_d[LOAD_STAGE]  = fill_data;
                ready_d[LOAD_STAGE] = 1'b1;
            end
            if (advance) begin
                for (int i = DEPTH - 1; i >= 1; i--) begin
                    valid_d[i] = valid_d[i-1];
                    ready_d[i] = ready_d[i-1];
                    rd_d[i]    = rd_d[i-1];
                    data_d[i]  = data_d[i-1];
                end
                valid_d[0] = new_wen && (new_rd != '0);
                ready_d[0] = new_ready;
                rd_d[0]    = new_rd;
                data_d[0]  = new_data;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            ready_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        bypass_port_sel #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .SEL_W  (SEL_W)
        ) u_sel (
            .valid_i   (valid_q),
            .rd_i      (rd_q),
            .data_i    (data_q),
            .ready_i   (ready_q),
            .rs_i      (rs[p*REG_AW +: REG_AW]),
            .rf_data_i (rf_data[p*DATA_W +: DATA_W]),
            .op_data_o (op_data[p*DATA_W +: DATA_W]),
            .fwd_sel_o (fwd_sel[p*SEL_W +: SEL_W]),
            .stall_o   (port_stall[p])
        );
    end

    assign stall = |port_stall;

endmodule
